// File: rtl/div_by_n_50dut.sv
// Programmable divide-by-N clock divider with runtime divisor reload via valid/ready.
// Optional macro DIV_ODD_50DUTY_EN adds a negedge flop for exact 50% duty at odd N.
module div_by_n_50dut #(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_valid,
  output logic             div_ready,
  output logic             out,
  output logic             period_tick,
  output logic [WIDTH-1:0] cur_div,
  inout  wire              VDD,
  inout  wire              VSS
);

  localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] MIN_DIV = WIDTH'(2);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] cur_div_q, cur_div_d;
  logic [WIDTH-1:0] pend_div_q, pend_div_d;
  logic             pend_q, pend_d;
  logic             out_pos_q, out_pos_d;
  logic             period_tick_q, period_tick_d;
  logic             accept;
  logic             unused_pwr;

  // Power pins carry no logic; fold them into a sink so they are not dangling.
  assign unused_pwr = VDD ^ VSS;

  assign accept = div_valid & ~pend_q;

  always_comb begin
    cnt_d         = cnt_q;
    cur_div_d     = cur_div_q;
    pend_d        = pend_q;
    pend_div_d    = pend_div_q;
    out_pos_d     = out_pos_q;
    period_tick_d = 1'b0;
    if (en) begin
      if (cnt_q == cur_div_q - ONE) begin
        cnt_d = '0;
        if (pend_q) begin
          cur_div_d = pend_div_q;
          pend_d    = 1'b0;
        end
      end else begin
        cnt_d = cnt_q + ONE;
      end
      // Phase decision uses the divisor in force after this edge.
      out_pos_d     = (cnt_d < (cur_div_d >> 1));
      period_tick_d = (cnt_d == '0);
    end
    // Acceptance needs pend_q low, so it never collides with an apply.
    if (accept) begin
      pend_d     = 1'b1;
      pend_div_d = (div_in < MIN_DIV) ? MIN_DIV : div_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q         <= DEF_DIV - ONE;
      cur_div_q     <= DEF_DIV;
      pend_div_q    <= DEF_DIV;
      pend_q        <= 1'b0;
      out_pos_q     <= 1'b0;
      period_tick_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      cur_div_q     <= cur_div_d;
      pend_div_q    <= pend_div_d;
      pend_q        <= pend_d;
      out_pos_q     <= out_pos_d;
      period_tick_q <= period_tick_d;
    end
  end

`ifdef DIV_ODD_50DUTY_EN
  logic out_neg_q, out_neg_d;

  always_comb begin
    out_neg_d = out_pos_q;
  end

  // Half-cycle delayed copy stretches the high phase by half a clock for odd N.
  always_ff @(negedge clk) begin
    if (!reset) begin
      out_neg_q <= 1'b0;
    end else begin
      out_neg_q <= out_neg_d;
    end
  end

  assign out = cur_div_q[0] ? (out_pos_q | out_neg_q) : out_pos_q;
`else
  assign out = out_pos_q;
`endif

  assign div_ready   = ~pend_q;
  assign period_tick = period_tick_q;
  assign cur_div     = cur_div_q;

endmodule
